// File: rtl/distribuidor_pkg.sv
// Shared constants, state encoding and card/score helpers for the blackjack card dealer.
package distribuidor_pkg;

    localparam int DECK_SIZE_PADRAO = 52;

    localparam logic [3:0] CARTA_AS     = 4'd1;
    localparam logic [3:0] CARTA_FIGURA = 4'd11;
    localparam logic [3:0] VALOR_FIGURA = 4'd10;
    localparam logic [5:0] HARD_MAX     = 6'd63;
    localparam logic [4:0] PONTOS_MAX   = 5'd31;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        PEDE_EMB   = 3'd1,
        ESPERA_EMB = 3'd2,
        PRONTO     = 3'd3,
        BUSCA      = 3'd4,
        ENTREGA    = 3'd5,
        VAZIO      = 3'd6
    } estado_t;

    function automatic logic carta_legal(input logic [3:0] codigo);
        return (codigo >= CARTA_AS) && (codigo <= CARTA_FIGURA);
    endfunction

    function automatic logic [3:0] valor_carta(input logic [3:0] codigo);
        return (codigo == CARTA_FIGURA) ? VALOR_FIGURA : codigo;
    endfunction

    // One ace counts as 11 whenever that does not bust the hand.
    function automatic logic [4:0] melhor_pontuacao(input logic [5:0] hard, input logic tem_as);
        logic [6:0] macio;
        macio = {1'b0, hard} + 7'd10;
        if (tem_as && (macio <= 7'd21)) begin
            return macio[4:0];
        end else if (hard > {1'b0, PONTOS_MAX}) begin
            return PONTOS_MAX;
        end else begin
            return hard[4:0];
        end
    endfunction

endpackage

// File: rtl/distribuidor_pontuador.sv
// One blackjack hand: saturating hard sum, ace flag and registered best score.
module pontuador
    import distribuidor_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       limpar,
    input  logic       somar,
    input  logic [3:0] valor,
    output logic [4:0] pontos
);

    logic [5:0] hard_r;
    logic [5:0] hard_prox_s;
    logic       tem_as_r;
    logic       tem_as_prox_s;
    logic [4:0] pontos_r;
    logic [6:0] soma_s;

    // Next hand contents from clear/add requests.
    always_comb begin
        soma_s        = {1'b0, hard_r} + {3'b000, valor};
        hard_prox_s   = hard_r;
        tem_as_prox_s = tem_as_r;
        if (limpar) begin
            hard_prox_s   = 6'd0;
            tem_as_prox_s = 1'b0;
        end else if (somar) begin
            hard_prox_s   = (soma_s > {1'b0, HARD_MAX}) ? HARD_MAX : soma_s[5:0];
            tem_as_prox_s = tem_as_r | (valor == CARTA_AS);
        end else begin
            hard_prox_s   = hard_r;
            tem_as_prox_s = tem_as_r;
        end
    end

    // Score is registered from the next-state values so it moves with the hand.
    always_ff @(posedge clock) begin
        if (reset) begin
            hard_r   <= 6'd0;
            tem_as_r <= 1'b0;
            pontos_r <= 5'd0;
        end else begin
            hard_r   <= hard_prox_s;
            tem_as_r <= tem_as_prox_s;
            pontos_r <= melhor_pontuacao(hard_prox_s, tem_as_prox_s);
        end
    end

    assign pontos = pontos_r;

endmodule

// File: rtl/distribuidor.sv
// Card dealer: shuffle handshake, deck pointer and card delivery to two hands.
module distribuidor #(
    parameter int DECK_SIZE       = distribuidor_pkg::DECK_SIZE_PADRAO,
    parameter int SHUFFLE_TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       novo_jogo,
    input  logic       pedir_carta,
    input  logic       destino,
    input  logic       embaralhar_ok,
    input  logic [3:0] q,
    output logic       embaralhar_start,
    output logic [5:0] ler_endereco,
    output logic [3:0] carta,
    output logic       carta_valida,
    output logic       pronto,
    output logic [4:0] soma_jogador,
    output logic [4:0] soma_dealer,
    output logic       baralho_vazio,
    output logic       erro
);

    import distribuidor_pkg::*;

    localparam int             TW              = $clog2(SHUFFLE_TIMEOUT + 1);
    localparam logic [TW-1:0]  ESPERA_ULTIMO   = TW'(SHUFFLE_TIMEOUT - 1);
    localparam logic [5:0]     PONTEIRO_ULTIMO = 6'(DECK_SIZE - 1);

    estado_t       estado_r;
    logic [5:0]    ponteiro_r;
    logic [TW-1:0] espera_r;
    logic          destino_r;
    logic [3:0]    carta_r;
    logic          carta_valida_r;
    logic          start_r;
    logic          pronto_r;
    logic          vazio_r;
    logic          erro_r;
    logic          limpar_s;
    logic          somar_j_s;
    logic          somar_d_s;

    assign limpar_s  = novo_jogo & ((estado_r == OCIOSO) | (estado_r == PRONTO));
    assign somar_j_s = (estado_r == ENTREGA) & ~destino_r;
    assign somar_d_s = (estado_r == ENTREGA) & destino_r;

    // Dealer FSM with pointer, timeout counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r       <= OCIOSO;
            ponteiro_r     <= 6'd0;
            espera_r       <= '0;
            destino_r      <= 1'b0;
            carta_r        <= 4'd0;
            carta_valida_r <= 1'b0;
            start_r        <= 1'b0;
            pronto_r       <= 1'b0;
            vazio_r        <= 1'b0;
            erro_r         <= 1'b0;
        end else begin
            carta_valida_r <= 1'b0;
            start_r        <= 1'b0;
            case (estado_r)
                OCIOSO: begin
                    if (novo_jogo && embaralhar_ok) begin
                        estado_r <= PRONTO;
                        pronto_r <= 1'b1;
                    end else if (novo_jogo) begin
                        estado_r <= PEDE_EMB;
                        start_r  <= 1'b1;
                    end else begin
                        estado_r <= OCIOSO;
                    end
                end
                PEDE_EMB: begin
                    estado_r <= ESPERA_EMB;
                    espera_r <= '0;
                end
                ESPERA_EMB: begin
                    if (embaralhar_ok) begin
                        estado_r <= PRONTO;
                        pronto_r <= 1'b1;
                    end else if (espera_r == ESPERA_ULTIMO) begin
                        estado_r <= OCIOSO;
                        erro_r   <= 1'b1;
                    end else begin
                        espera_r <= espera_r + TW'(1);
                    end
                end
                PRONTO: begin
                    // A new round beats a simultaneous draw request.
                    if (novo_jogo && !embaralhar_ok) begin
                        estado_r <= PEDE_EMB;
                        pronto_r <= 1'b0;
                        start_r  <= 1'b1;
                    end else if (novo_jogo) begin
                        estado_r <= PRONTO;
                    end else if (pedir_carta) begin
                        estado_r  <= BUSCA;
                        pronto_r  <= 1'b0;
                        destino_r <= destino;
                    end else begin
                        estado_r <= PRONTO;
                    end
                end
                BUSCA: begin
                    if (carta_legal(q)) begin
                        estado_r       <= ENTREGA;
                        carta_r        <= valor_carta(q);
                        carta_valida_r <= 1'b1;
                    end else begin
                        estado_r <= PRONTO;
                        pronto_r <= 1'b1;
                        erro_r   <= 1'b1;
                    end
                end
                ENTREGA: begin
                    ponteiro_r <= ponteiro_r + 6'd1;
                    if (ponteiro_r == PONTEIRO_ULTIMO) begin
                        estado_r <= VAZIO;
                        vazio_r  <= 1'b1;
                    end else begin
                        estado_r <= PRONTO;
                        pronto_r <= 1'b1;
                    end
                end
                VAZIO: begin
                    estado_r <= VAZIO;
                end
                default: begin
                    estado_r <= OCIOSO;
                    pronto_r <= 1'b0;
                end
            endcase
        end
    end

    pontuador u_mao_jogador (
        .clock  (clock),
        .reset  (reset),
        .limpar (limpar_s),
        .somar  (somar_j_s),
        .valor  (carta_r),
        .pontos (soma_jogador)
    );

    pontuador u_mao_dealer (
        .clock  (clock),
        .reset  (reset),
        .limpar (limpar_s),
        .somar  (somar_d_s),
        .valor  (carta_r),
        .pontos (soma_dealer)
    );

    assign embaralhar_start = start_r;
    assign ler_endereco     = ponteiro_r;
    assign carta            = carta_r;
    assign carta_valida     = carta_valida_r;
    assign pronto           = pronto_r;
    assign baralho_vazio    = vazio_r;
    assign erro             = erro_r;

endmodule

// File: tb/tb_distribuidor.sv
// Randomized bench for distribuidor with a transaction-level model of rounds, draws and hands.
module tb_distribuidor;

    localparam int DECK = 52;
    localparam int TMO  = 24;

    logic       clock = 1'b0;
    logic       reset, novo_jogo, pedir_carta, destino, embaralhar_ok;
    logic [3:0] q;
    logic       embaralhar_start, carta_valida, pronto, baralho_vazio, erro;
    logic [5:0] ler_endereco;
    logic [3:0] carta;
    logic [4:0] soma_jogador, soma_dealer;

    logic [3:0] deck [0:63];
    assign q = deck[ler_endereco];

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    logic e_start, e_pronto, e_cv, e_vazio, e_erro;
    logic [3:0] e_carta;
    int   e_ptr;
    int   tot [2];
    bit   ace [2];

    distribuidor #(.DECK_SIZE(DECK), .SHUFFLE_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .novo_jogo(novo_jogo), .pedir_carta(pedir_carta),
        .destino(destino), .embaralhar_ok(embaralhar_ok), .q(q),
        .embaralhar_start(embaralhar_start), .ler_endereco(ler_endereco), .carta(carta),
        .carta_valida(carta_valida), .pronto(pronto), .soma_jogador(soma_jogador),
        .soma_dealer(soma_dealer), .baralho_vazio(baralho_vazio), .erro(erro)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nome, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nome, $time, act, exp);
        end
    endtask

    // Best blackjack total: one ace may count 11 if the hand stays at or under 21.
    function automatic int score(input int t, input bit a);
        int h;
        h = (t > 63) ? 63 : t;
        if (a && (h + 10 <= 21)) return h + 10;
        return (h > 31) ? 31 : h;
    endfunction

    function automatic int pts(input int c);
        return (c == 11) ? 10 : c;
    endfunction

    function automatic logic [3:0] legal_card();
        return 4'($urandom_range(1, 11));
    endfunction

    // Compare every output against the model each cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("embaralhar_start", {7'd0, embaralhar_start}, {7'd0, e_start});
            chk("pronto", {7'd0, pronto}, {7'd0, e_pronto});
            chk("carta_valida", {7'd0, carta_valida}, {7'd0, e_cv});
            chk("carta", {4'd0, carta}, {4'd0, e_carta});
            chk("baralho_vazio", {7'd0, baralho_vazio}, {7'd0, e_vazio});
            chk("erro", {7'd0, erro}, {7'd0, e_erro});
            chk("ler_endereco", {2'd0, ler_endereco}, 8'(e_ptr));
            chk("soma_jogador", {3'd0, soma_jogador}, 8'(score(tot[0], ace[0])));
            chk("soma_dealer", {3'd0, soma_dealer}, 8'(score(tot[1], ace[1])));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_hands();
        tot[0] = 0; tot[1] = 0; ace[0] = 1'b0; ace[1] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; novo_jogo = 1'b0; pedir_carta = 1'b0;
        step();
        reset = 1'b0;
        e_start = 1'b0; e_pronto = 1'b0; e_cv = 1'b0; e_vazio = 1'b0; e_erro = 1'b0;
        e_carta = 4'd0; e_ptr = 0;
        clear_hands();
    endtask

    // New round; when the shuffle is not ready, ok rises 'delay' cycles into the wait.
    task automatic new_game(input bit ok_now, input int delay);
        novo_jogo = 1'b1; pedir_carta = 1'($urandom_range(0, 1)); destino = 1'($urandom_range(0, 1));
        embaralhar_ok = ok_now;
        step();
        novo_jogo = 1'b0; pedir_carta = 1'b0;
        clear_hands();
        if (ok_now) begin
            e_pronto = 1'b1;
            return;
        end
        e_pronto = 1'b0; e_start = 1'b1;
        step();
        e_start = 1'b0;
        for (int k = 0; k <= TMO; k++) begin
            if (k == delay) begin
                embaralhar_ok = 1'b1;
                step();
                e_pronto = 1'b1;
                return;
            end
            step();
            if (k + 1 == TMO) begin
                e_erro = 1'b1;
                return;
            end
        end
    endtask

    task automatic draw(input bit dest);
        logic [3:0] code;
        pedir_carta = 1'b1; destino = dest;
        step();
        e_pronto = 1'b0;
        pedir_carta = 1'b1; destino = ~dest; novo_jogo = 1'($urandom_range(0, 1));
        step();
        code = deck[e_ptr];
        pedir_carta = 1'b0; novo_jogo = 1'b0;
        if (code == 4'd0 || code > 4'd11) begin
            e_erro = 1'b1; e_pronto = 1'b1;
            return;
        end
        e_cv = 1'b1; e_carta = 4'(pts(int'(code)));
        novo_jogo = 1'($urandom_range(0, 1)); pedir_carta = 1'($urandom_range(0, 1));
        step();
        novo_jogo = 1'b0; pedir_carta = 1'b0;
        e_cv = 1'b0;
        tot[dest] += pts(int'(code));
        if (code == 4'd1) ace[dest] = 1'b1;
        e_ptr++;
        if (e_ptr == DECK) e_vazio = 1'b1;
        else e_pronto = 1'b1;
    endtask

    initial begin
        int guard;
        reset = 1'b1; novo_jogo = 1'b0; pedir_carta = 1'b0; destino = 1'b0; embaralhar_ok = 1'b0;
        for (int i = 0; i < 64; i++) deck[i] = legal_card();

        do_reset();
        chk_en = 1'b1;
        chk("reset_pronto", {7'd0, pronto}, 8'd0);
        chk("reset_ler_endereco", {2'd0, ler_endereco}, 8'd0);
        chk("reset_soma_jogador", {3'd0, soma_jogador}, 8'd0);

        // Shuffle never completes: timeout back to idle, then idle accepts a ready round.
        new_game(1'b0, TMO + 3);
        chk("timeout_erro", {7'd0, erro}, 8'd1);
        chk("timeout_pronto", {7'd0, pronto}, 8'd0);
        new_game(1'b1, 0);
        chk("ocioso_to_pronto", {7'd0, pronto}, 8'd1);
        do_reset();
        chk("reset_clears_erro", {7'd0, erro}, 8'd0);

        // Reset during BUSCA and during ENTREGA abort the draw.
        new_game(1'b1, 0);
        pedir_carta = 1'b1; destino = 1'b0;
        step();
        pedir_carta = 1'b0; e_pronto = 1'b0;
        do_reset();
        new_game(1'b1, 0);
        pedir_carta = 1'b1; destino = 1'b0;
        step();
        pedir_carta = 1'b0; e_pronto = 1'b0;
        step();
        e_cv = 1'b1; e_carta = 4'(pts(int'(deck[0])));
        do_reset();
        chk("abort_carta_valida", {7'd0, carta_valida}, 8'd0);
        chk("abort_soma_jogador", {3'd0, soma_jogador}, 8'd0);

        // Shuffle handshake, then ace / figure / five scoring.
        deck[0] = 4'd1; deck[1] = 4'd11; deck[2] = 4'd5;
        new_game(1'b0, 4);
        draw(1'b0);
        chk("ace_carta", {4'd0, carta}, 8'd1);
        chk("ace_soma", {3'd0, soma_jogador}, 8'd11);
        draw(1'b0);
        chk("figura_carta", {4'd0, carta}, 8'd10);
        chk("blackjack_soma", {3'd0, soma_jogador}, 8'd21);
        draw(1'b0);
        chk("soft_ace_soma", {3'd0, soma_jogador}, 8'd16);

        // Illegal code: error, pointer held.
        deck[3] = 4'd0;
        draw(1'b1);
        chk("illegal_erro", {7'd0, erro}, 8'd1);
        chk("illegal_ptr", {2'd0, ler_endereco}, 8'd3);
        deck[3] = legal_card();

        guard = 0;
        while (e_ptr < DECK && guard < 3000) begin
            int r;
            guard++;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                new_game(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
            end else if (r == 1) begin
                repeat ($urandom_range(1, 3)) step();
            end else if ($urandom_range(0, 11) == 0) begin
                deck[e_ptr] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(12, 15));
                draw(1'($urandom_range(0, 1)));
                deck[e_ptr] = legal_card();
            end else begin
                draw(1'($urandom_range(0, 1)));
            end
        end
        chk("deck_exhausted_in_budget", 8'(e_ptr), 8'(DECK));

        // Empty deck ignores further requests.
        chk("vazio_flag", {7'd0, baralho_vazio}, 8'd1);
        chk("vazio_ptr", {2'd0, ler_endereco}, 8'd52);
        pedir_carta = 1'b1;
        step();
        pedir_carta = 1'b0; novo_jogo = 1'b1;
        step();
        novo_jogo = 1'b0;
        repeat (4) step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/distribuidor.md
DISTRIBUIDOR -- requirements
Module: distribuidor

Interface
REQ-001 Parameter DECK_SIZE, default 52: number of cards served before the deck is exhausted.
REQ-002 Parameter SHUFFLE_TIMEOUT, default 1024: maximum cycles to wait for embaralhar_ok.
REQ-003 clock  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 novo_jogo  in  1  one-cycle pulse; clears both hands and starts a round.
REQ-006 pedir_carta  in  1  one-cycle draw request.
REQ-007 destino  in  1  sampled with pedir_carta; 0 = jogador hand, 1 = dealer hand.
REQ-008 embaralhar_ok  in  1  shuffle-complete level from the deck.
REQ-009 q  in  4  card code from the deck at ler_endereco; 1 = ace, 2..10 = pips, 11 = J/Q/K.
REQ-010 embaralhar_start  out  1  one-cycle pulse requesting a shuffle.
REQ-011 ler_endereco  out  6  deck read address, equal to the deck pointer.
REQ-012 carta  out  4  point value of the last delivered card (1..10).
REQ-013 carta_valida  out  1  one-cycle strobe qualifying carta.
REQ-014 pronto  out  1  high only in state PRONTO.
REQ-015 soma_jogador, soma_dealer  out  5 each  best blackjack score of each hand.
REQ-016 baralho_vazio  out  1  high once DECK_SIZE cards have been dealt.
REQ-017 erro  out  1  sticky error flag (timeout or illegal card code).

Function
REQ-018 FSM states: OCIOSO, PEDE_EMB, ESPERA_EMB, PRONTO, BUSCA, ENTREGA, VAZIO.
REQ-019 OCIOSO plus novo_jogo: clear both hands; go to PRONTO if embaralhar_ok = 1, else go to PEDE_EMB.
REQ-020 PEDE_EMB: assert embaralhar_start for exactly one cycle, then go to ESPERA_EMB.
REQ-021 ESPERA_EMB: go to PRONTO on embaralhar_ok = 1; after SHUFFLE_TIMEOUT cycles without it, set erro and return to OCIOSO.
REQ-022 PRONTO plus pedir_carta at cycle N: latch destino and go to BUSCA at N+1.
REQ-023 BUSCA: capture q at the end of the cycle and go to ENTREGA.
REQ-024 ENTREGA (cycle N+2): carta_valida = 1; carta = q mapped (11 -> 10, otherwise unchanged).
REQ-025 Also in ENTREGA: update the latched hand, increment the pointer, then go to PRONTO at N+3, or to VAZIO if the pointer reaches DECK_SIZE.
REQ-026 pedir_carta outside PRONTO is ignored, not queued.
REQ-027 novo_jogo in PRONTO clears both hands and returns via the REQ-019 check.
REQ-028 novo_jogo in BUSCA or ENTREGA is ignored.
REQ-029 The deck pointer is cleared only by reset; it is not rewound by novo_jogo.
REQ-030 Illegal q (0 or >11) in BUSCA: set erro, deliver no card, leave hand and pointer unchanged, return to PRONTO.
REQ-031 Each hand keeps a 6-bit hard sum (ace = 1, saturating at 63) and a tem_as flag.
REQ-032 Score = hard + 10 if tem_as and hard + 10 <= 21; otherwise hard, saturated to 31.
REQ-033 VAZIO: baralho_vazio = 1, pronto = 0, pedir_carta and novo_jogo ignored; exit only by reset.
REQ-034 pedir_carta and novo_jogo in the same PRONTO cycle: novo_jogo wins and the draw is dropped.

Reset
REQ-035 Reset SHALL force state OCIOSO and pointer 0.
REQ-036 Reset SHALL clear hard sums, tem_as flags and the timeout counter.
REQ-037 Reset SHALL drive 0 on all outputs.
REQ-038 Reset mid-BUSCA/ENTREGA SHALL abort with no carta_valida and no hand update.
REQ-039 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-040 A shared package SHALL hold DECK_SIZE, card code constants (AS = 1, FIGURA = 11) and the state encoding.
REQ-041 Hand scoring SHALL be a sub-module pontuador (clear, add, value in; score out), instantiated twice.
REQ-042 The top level SHALL contain only the FSM, pointer and timeout counter.

Verification
REQ-043 Shuffle: embaralhar_ok = 0, novo_jogo -> one-cycle embaralhar_start; ok raised 5 cycles later -> pronto 1 cycle after ok.
REQ-044 Timeout: ok held 0 -> erro = 1 and state OCIOSO exactly SHUFFLE_TIMEOUT cycles after ESPERA_EMB entry.
REQ-045 Scoring: jogador draws q = 1 then 11 -> carta 1 then 10; soma_jogador 11 then 21.
REQ-046 Soft ace: a further q = 5 -> soma_jogador = 16.
REQ-047 Deck end: 52 draws -> ler_endereco 0..51; baralho_vazio = 1 after the 52nd carta_valida; a 53rd request gives no strobe.
REQ-048 Corner cases: pedir_carta in BUSCA ignored; q = 0 -> erro = 1 with pointer unchanged; reset in ENTREGA -> no strobe, all outputs 0.
